// File: rtl/cpu_pkg.sv
// Shared constants, requester IDs and a register-address decode helper
// for the write-back path.
package cpu_pkg;

   localparam int DATA_W   = 8;
   localparam int ADDR_W   = 3;
   localparam int NUM_REGS = 8;

   typedef enum logic {
      REQ_ALU = 1'b0,
      REQ_LD  = 1'b1
   } req_id_e;

   function automatic logic [NUM_REGS-1:0] addr_dec(input logic [ADDR_W-1:0] addr);
      logic [NUM_REGS-1:0] mask;
      mask       = {NUM_REGS{1'b0}};
      mask[addr] = 1'b1;
      return mask;
   endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Producer-side handshakes and the register-file write port of the
// write-back arbiter.
interface regfile_wb_arbiter_if;
   import cpu_pkg::*;

   logic              alu_valid;
   logic [ADDR_W-1:0] alu_addr;
   logic [DATA_W-1:0] alu_data;
   logic              alu_ready;
   logic              ld_valid;
   logic [ADDR_W-1:0] ld_addr;
   logic [DATA_W-1:0] ld_data;
   logic              ld_ready;
   logic              rf_write_en;
   logic [ADDR_W-1:0] rf_wr_addr;
   logic [DATA_W-1:0] rf_wr_data;

   modport master (
      output alu_valid, alu_addr, alu_data, ld_valid, ld_addr, ld_data,
      input  alu_ready, ld_ready, rf_write_en, rf_wr_addr, rf_wr_data
   );

   modport slave (
      input  alu_valid, alu_addr, alu_data, ld_valid, ld_addr, ld_data,
      output alu_ready, ld_ready, rf_write_en, rf_wr_addr, rf_wr_data
   );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter with stall; req[0]/grant[0] is the ALU,
// req[1]/grant[1] the load path. The pointer names the preferred requester.
module rr_arbiter2
   import cpu_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       stall,
   output logic [1:0] grant
);

   req_id_e    ptr_r;
   logic [1:0] grant_s;

   // Grant selection: a lone requester always wins, contention follows the pointer.
   always_comb begin
      grant_s = 2'b00;
      if (stall) begin
         grant_s = 2'b00;
      end else begin
         case (req)
            2'b01:   grant_s = 2'b01;
            2'b10:   grant_s = 2'b10;
            2'b11:   grant_s = (ptr_r == REQ_LD) ? 2'b10 : 2'b01;
            default: grant_s = 2'b00;
         endcase
      end
   end

   // Pointer moves to the loser only after a contended grant.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_r <= REQ_ALU;
      end else if (!stall && (req == 2'b11)) begin
         ptr_r <= (ptr_r == REQ_ALU) ? REQ_LD : REQ_ALU;
      end else begin
         ptr_r <= ptr_r;
      end
   end

   assign grant = grant_s;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back controller: arbitrates ALU and load results onto the single
// register-file write port and tracks pending destinations for hazard checks.
module regfile_wb_arbiter
   import cpu_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   regfile_wb_arbiter_if.slave  bus,
   input  logic                 wb_stall,
   input  logic                 alloc_en,
   input  logic [ADDR_W-1:0]    alloc_addr,
   input  logic [ADDR_W-1:0]    rd_addr1,
   input  logic [ADDR_W-1:0]    rd_addr2,
   output logic                 hazard1,
   output logic                 hazard2,
   output logic [NUM_REGS-1:0]  pending,
   output logic                 err_spurious
);

   logic [1:0]          grant_s;
   logic [ADDR_W-1:0]   sel_addr_s;
   logic [DATA_W-1:0]   sel_data_s;
   logic [NUM_REGS-1:0] set_mask_s;
   logic [NUM_REGS-1:0] clr_mask_s;

   logic                wr_en_r;
   logic [ADDR_W-1:0]   wr_addr_r;
   logic [DATA_W-1:0]   wr_data_r;
   logic [NUM_REGS-1:0] pending_r;
   logic                err_r;

   rr_arbiter2 u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .req   ({bus.ld_valid, bus.alu_valid}),
      .stall (wb_stall),
      .grant (grant_s)
   );

   // Route the winning requester's address and data to the port register.
   always_comb begin
      sel_addr_s = bus.alu_addr;
      sel_data_s = bus.alu_data;
      if (grant_s[1]) begin
         sel_addr_s = bus.ld_addr;
         sel_data_s = bus.ld_data;
      end else begin
         sel_addr_s = bus.alu_addr;
         sel_data_s = bus.alu_data;
      end
   end

   // Write port register: an accept in one cycle becomes a commit in the next.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_en_r   <= 1'b0;
         wr_addr_r <= {ADDR_W{1'b0}};
         wr_data_r <= {DATA_W{1'b0}};
      end else if (|grant_s) begin
         wr_en_r   <= 1'b1;
         wr_addr_r <= sel_addr_s;
         wr_data_r <= sel_data_s;
      end else begin
         wr_en_r   <= 1'b0;
         wr_addr_r <= wr_addr_r;
         wr_data_r <= wr_data_r;
      end
   end

   // Scoreboard masks for this edge; OR-ing the set last lets a new allocation supersede a commit.
   always_comb begin
      set_mask_s = {NUM_REGS{1'b0}};
      clr_mask_s = {NUM_REGS{1'b0}};
      if (alloc_en) begin
         set_mask_s = addr_dec(alloc_addr);
      end else begin
         set_mask_s = {NUM_REGS{1'b0}};
      end
      if (wr_en_r) begin
         clr_mask_s = addr_dec(wr_addr_r);
      end else begin
         clr_mask_s = {NUM_REGS{1'b0}};
      end
   end

   // Pending vector and sticky spurious-commit flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_r <= {NUM_REGS{1'b0}};
         err_r     <= 1'b0;
      end else begin
         pending_r <= (pending_r & ~clr_mask_s) | set_mask_s;
         if (wr_en_r && !pending_r[wr_addr_r]) begin
            err_r <= 1'b1;
         end else begin
            err_r <= err_r;
         end
      end
   end

   assign bus.alu_ready   = grant_s[0];
   assign bus.ld_ready    = grant_s[1];
   assign bus.rf_write_en = wr_en_r;
   assign bus.rf_wr_addr  = wr_addr_r;
   assign bus.rf_wr_data  = wr_data_r;
   assign pending         = pending_r;
   assign err_spurious    = err_r;
   assign hazard1         = pending_r[rd_addr1];
   assign hazard2         = pending_r[rd_addr2];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for the write-back arbiter: expected commits are queued as
// stimulus is issued and a negedge monitor checks each register-file write.
module tb_regfile_wb_arbiter;
   import cpu_pkg::*;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wb_t;

   logic                clk;
   logic                rst_n;
   logic                wb_stall;
   logic                alloc_en;
   logic [ADDR_W-1:0]   alloc_addr;
   logic [ADDR_W-1:0]   rd_addr1;
   logic [ADDR_W-1:0]   rd_addr2;
   logic                hazard1;
   logic                hazard2;
   logic [NUM_REGS-1:0] pending;
   logic                err_spurious;

   int  n_total = 0;
   int  n_pass  = 0;
   wb_t exp_q[$];

   regfile_wb_arbiter_if bus ();

   regfile_wb_arbiter dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .bus          (bus),
      .wb_stall     (wb_stall),
      .alloc_en     (alloc_en),
      .alloc_addr   (alloc_addr),
      .rd_addr1     (rd_addr1),
      .rd_addr2     (rd_addr2),
      .hazard1      (hazard1),
      .hazard2      (hazard2),
      .pending      (pending),
      .err_spurious (err_spurious)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic wb_t mk(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      wb_t w;
      w.addr = a;
      w.data = d;
      return w;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_alloc(input logic [ADDR_W-1:0] a);
      alloc_en   = 1'b1;
      alloc_addr = a;
      step();
      alloc_en   = 1'b0;
   endtask

   task automatic chk_ready(input string name, input logic alu_r, input logic ld_r);
      chk({name, "_alu_ready"}, bus.alu_ready, alu_r);
      chk({name, "_ld_ready"},  bus.ld_ready,  ld_r);
   endtask

   // Monitor: every committed write must match the oldest queued expectation.
   always @(negedge clk) begin
      if (rst_n && bus.rf_write_en) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_write", {21'd0, bus.rf_wr_addr, bus.rf_wr_data}, 32'hFFFF_FFFF);
         end else begin
            wb_t e;
            e = exp_q.pop_front();
            chk("wb_addr", bus.rf_wr_addr, e.addr);
            chk("wb_data", bus.rf_wr_data, e.data);
         end
      end
   end

   initial begin
      rst_n         = 1'b0;
      wb_stall      = 1'b0;
      alloc_en      = 1'b0;
      alloc_addr    = 3'd0;
      rd_addr1      = 3'd0;
      rd_addr2      = 3'd0;
      bus.alu_valid = 1'b0;
      bus.alu_addr  = 3'd0;
      bus.alu_data  = 8'd0;
      bus.ld_valid  = 1'b0;
      bus.ld_addr   = 3'd0;
      bus.ld_data   = 8'd0;
      #2;
      chk("rst_write_en", bus.rf_write_en, 1'b0);
      chk("rst_pending", pending, 8'h00);
      chk("rst_err", err_spurious, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      @(negedge clk);
      chk("idle_write_en", bus.rf_write_en, 1'b0);
      chk("idle_wr_addr", bus.rf_wr_addr, 3'd0);
      chk("idle_wr_data", bus.rf_wr_data, 8'd0);
      chk("idle_pending", pending, 8'h00);
      chk("idle_hazard1", hazard1, 1'b0);
      chk_ready("idle", 1'b0, 1'b0);
      step();

      // Single write to R2
      do_alloc(3'd2);
      bus.alu_valid = 1'b1; bus.alu_addr = 3'd2; bus.alu_data = 8'd42; rd_addr1 = 3'd2;
      exp_q.push_back(mk(3'd2, 8'd42));
      @(negedge clk);
      chk_ready("single", 1'b1, 1'b0);
      chk("single_pending_c1", pending, 8'h04);
      chk("single_hazard_c1", hazard1, 1'b1);
      step();
      bus.alu_valid = 1'b0;
      @(negedge clk);
      chk("single_write_en_c2", bus.rf_write_en, 1'b1);
      chk("single_pending_c2", pending, 8'h04);
      chk("single_hazard_c2", hazard1, 1'b1);
      step();
      @(negedge clk);
      chk("single_pending_c3", pending, 8'h00);
      chk("single_hazard_c3", hazard1, 1'b0);
      step();

      // Contention: ALU R4/100 vs LD R1/7 for four cycles
      do_alloc(3'd4);
      do_alloc(3'd1);
      for (int k = 0; k < 4; k++) begin
         bus.alu_valid = 1'b1; bus.alu_addr = 3'd4; bus.alu_data = 8'd100;
         bus.ld_valid  = 1'b1; bus.ld_addr  = 3'd1; bus.ld_data  = 8'd7;
         alloc_en   = (k >= 2);
         alloc_addr = (k == 2) ? 3'd4 : 3'd1;
         if (k % 2 == 0) exp_q.push_back(mk(3'd4, 8'd100));
         else            exp_q.push_back(mk(3'd1, 8'd7));
         @(negedge clk);
         chk_ready($sformatf("contend%0d", k), (k % 2 == 0), (k % 2 == 1));
         step();
      end
      bus.alu_valid = 1'b0; bus.ld_valid = 1'b0; alloc_en = 1'b0;
      step();
      @(negedge clk);
      chk("contend_pending", pending, 8'h00);
      chk("contend_err", err_spurious, 1'b0);
      step();

      // Lone ALU grant leaves the pointer on ALU, then contention alternates
      do_alloc(3'd6);
      do_alloc(3'd7);
      bus.alu_valid = 1'b1; bus.alu_addr = 3'd6; bus.alu_data = 8'h11;
      exp_q.push_back(mk(3'd6, 8'h11));
      @(negedge clk);
      chk_ready("lone_a", 1'b1, 1'b0);
      step();
      bus.alu_data = 8'h22; bus.ld_valid = 1'b1; bus.ld_addr = 3'd7; bus.ld_data = 8'h33;
      alloc_en = 1'b1; alloc_addr = 3'd6;
      exp_q.push_back(mk(3'd6, 8'h22));
      @(negedge clk);
      chk_ready("lone_b", 1'b1, 1'b0);
      step();
      bus.alu_data = 8'h44;
      exp_q.push_back(mk(3'd7, 8'h33));
      @(negedge clk);
      chk_ready("lone_c", 1'b0, 1'b1);
      chk("same_edge_r6_c", pending[6], 1'b1);
      step();
      bus.ld_valid = 1'b0; alloc_en = 1'b0;
      exp_q.push_back(mk(3'd6, 8'h44));
      @(negedge clk);
      chk_ready("lone_d", 1'b1, 1'b0);
      chk("same_edge_r6_d", pending[6], 1'b1);
      step();
      bus.alu_valid = 1'b0;
      step();
      @(negedge clk);
      chk("lone_pending", pending, 8'h00);
      step();

      // Same-edge set/clear on R3
      do_alloc(3'd3);
      bus.alu_valid = 1'b1; bus.alu_addr = 3'd3; bus.alu_data = 8'h55;
      exp_q.push_back(mk(3'd3, 8'h55));
      step();
      bus.alu_valid = 1'b0; alloc_en = 1'b1; alloc_addr = 3'd3;
      step();
      alloc_en = 1'b0; rd_addr2 = 3'd3;
      @(negedge clk);
      chk("same_edge_r3_pending", pending, 8'h08);
      chk("same_edge_r3_hazard2", hazard2, 1'b1);
      bus.alu_valid = 1'b1; bus.alu_data = 8'h56;
      exp_q.push_back(mk(3'd3, 8'h56));
      step();
      bus.alu_valid = 1'b0;
      step();
      @(negedge clk);
      chk("r3_cleanup_pending", pending, 8'h00);
      chk("r3_cleanup_hazard2", hazard2, 1'b0);
      step();

      // Stall with both valid: nothing accepted, pointer order resumes at ALU
      bus.alu_valid = 1'b1; bus.alu_addr = 3'd4; bus.alu_data = 8'h66;
      bus.ld_valid  = 1'b1; bus.ld_addr  = 3'd1; bus.ld_data  = 8'h77;
      wb_stall = 1'b1; alloc_en = 1'b1; alloc_addr = 3'd4;
      @(negedge clk);
      chk_ready("stall0", 1'b0, 1'b0);
      step();
      alloc_addr = 3'd1;
      @(negedge clk);
      chk_ready("stall1", 1'b0, 1'b0);
      chk("stall1_write_en", bus.rf_write_en, 1'b0);
      step();
      wb_stall = 1'b0; alloc_en = 1'b0;
      exp_q.push_back(mk(3'd4, 8'h66));
      @(negedge clk);
      chk("stall2_write_en", bus.rf_write_en, 1'b0);
      chk_ready("resume0", 1'b1, 1'b0);
      step();
      bus.alu_data = 8'h88; alloc_en = 1'b1; alloc_addr = 3'd4;
      exp_q.push_back(mk(3'd1, 8'h77));
      @(negedge clk);
      chk_ready("resume1", 1'b0, 1'b1);
      step();
      bus.ld_valid = 1'b0; alloc_en = 1'b0;
      exp_q.push_back(mk(3'd4, 8'h88));
      @(negedge clk);
      chk_ready("resume2", 1'b1, 1'b0);
      step();
      bus.alu_valid = 1'b0;
      step();
      @(negedge clk);
      chk("stall_pending", pending, 8'h00);
      chk("stall_err", err_spurious, 1'b0);
      step();

      // Spurious commit to R5
      bus.alu_valid = 1'b1; bus.alu_addr = 3'd5; bus.alu_data = 8'h5a;
      exp_q.push_back(mk(3'd5, 8'h5a));
      @(negedge clk);
      chk_ready("spur", 1'b1, 1'b0);
      step();
      bus.alu_valid = 1'b0;
      @(negedge clk);
      chk("spur_err_before_edge", err_spurious, 1'b0);
      step();
      @(negedge clk);
      chk("spur_err_set", err_spurious, 1'b1);
      chk("spur_pending", pending, 8'h00);
      step();
      step();
      @(negedge clk);
      chk("spur_err_sticky", err_spurious, 1'b1);
      step();

      // Asynchronous reset during a commit with R2/R4 pending
      do_alloc(3'd2);
      alloc_en = 1'b1; alloc_addr = 3'd4;
      bus.alu_valid = 1'b1; bus.alu_addr = 3'd0; bus.alu_data = 8'h99;
      step();
      alloc_en = 1'b0; bus.alu_valid = 1'b0;
      chk("pre_arst_write_en", bus.rf_write_en, 1'b1);
      chk("pre_arst_data", bus.rf_wr_data, 8'h99);
      chk("pre_arst_pending", pending, 8'h14);
      #1;
      rst_n = 1'b0;
      #1;
      chk("arst_write_en", bus.rf_write_en, 1'b0);
      chk("arst_wr_data", bus.rf_wr_data, 8'h00);
      chk("arst_pending", pending, 8'h00);
      chk("arst_err", err_spurious, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      @(negedge clk);
      chk("post_arst_write_en", bus.rf_write_en, 1'b0);
      chk("exp_queue_drained", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
